mode_acc_reg: RTL and testbench

Parametrised accumulator register: the successor to the fixed 4-bit load/double/increment register. Adds generic width and shift, decrement, add/subtract, sticky overflow, clear, and a self-running count-to-limit mode with busy/done status. It sits in the datapath as a general-purpose programmable register and counter driven by a 3-bit opcode from the control unit.

---
 rtl/mode_acc_reg.sv | 130 +++++++++++++
 tb/tb_mode_acc_reg.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/mode_acc_reg.sv
// Programmable accumulator register with a self-running count-to-limit mode.
// Optional feature: define SAT_EN to clamp overflowing results instead of wrapping.
module mode_acc_reg #(
  parameter int WIDTH = 4,
  parameter int SHIFT = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_data_in,
  output logic [WIDTH-1:0] o_data_out,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_ovf,
  output logic             o_zero
);

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_LSHL  = 3'b001;
  localparam logic [2:0] OP_INC   = 3'b010;
  localparam logic [2:0] OP_DEC   = 3'b011;
  localparam logic [2:0] OP_ADD   = 3'b100;
  localparam logic [2:0] OP_SUB   = 3'b101;
  localparam logic [2:0] OP_COUNT = 3'b110;
  localparam logic [2:0] OP_CLR   = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_data, w_data_next;
  logic [WIDTH-1:0] r_limit, w_limit_next;
  logic             r_ovf, w_ovf_next;

  logic [WIDTH:0]   w_one;
  logic [WIDTH:0]   w_inc, w_dec, w_add, w_sub;
  logic [WIDTH-1:0] w_shl;
  logic             w_shl_lost;
  logic [WIDTH-1:0] w_res, w_arith;
  logic             w_of, w_sat_hi;

  // All arithmetic carries one extra bit so carry/borrow falls out as the MSB.
  assign w_one      = {{WIDTH{1'b0}}, 1'b1};
  assign w_inc      = {1'b0, r_data} + w_one;
  assign w_dec      = {1'b0, r_data} - w_one;
  assign w_add      = {1'b0, r_data} + {1'b0, i_data_in};
  assign w_sub      = {1'b0, r_data} - {1'b0, i_data_in};
  assign w_shl      = i_data_in << SHIFT;
  assign w_shl_lost = |i_data_in[WIDTH-1 -: SHIFT];

  always_comb begin
    w_res    = i_data_in;
    w_of     = 1'b0;
    w_sat_hi = 1'b1;
    case (i_op)
      OP_LSHL: begin w_res = w_shl; w_of = w_shl_lost; end
      OP_INC:  {w_of, w_res} = w_inc;
      OP_DEC:  begin {w_of, w_res} = w_dec; w_sat_hi = 1'b0; end
      OP_ADD:  {w_of, w_res} = w_add;
      OP_SUB:  begin {w_of, w_res} = w_sub; w_sat_hi = 1'b0; end
      default: w_res = i_data_in;
    endcase
`ifdef SAT_EN
    w_arith = w_of ? (w_sat_hi ? {WIDTH{1'b1}} : {WIDTH{1'b0}}) : w_res;
`else
    w_arith = w_res;
`endif
  end

  always_comb begin
    w_state_next = r_state;
    w_data_next  = r_data;
    w_limit_next = r_limit;
    w_ovf_next   = r_ovf;
    case (r_state)
      S_RUN: begin
        if (i_en && i_op == OP_CLR) begin
          w_state_next = S_IDLE;
          w_data_next  = '0;
          w_ovf_next   = 1'b0;
        end else if (r_data == r_limit) begin
          w_state_next = S_DONE;
        end else begin
          w_data_next = w_inc[WIDTH-1:0];
        end
      end
      default: begin
        // DONE lasts one cycle and otherwise behaves exactly like IDLE.
        w_state_next = S_IDLE;
        if (i_en) begin
          case (i_op)
            OP_CLR: begin
              w_data_next = '0;
              w_ovf_next  = 1'b0;
            end
            OP_COUNT: begin
              w_limit_next = i_data_in;
              w_state_next = S_RUN;
            end
            default: begin
              w_data_next = w_arith;
              w_ovf_next  = r_ovf | w_of;
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_limit <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_data  <= w_data_next;
      r_limit <= w_limit_next;
      r_ovf   <= w_ovf_next;
    end
  end

  assign o_data_out = r_data;
  assign o_busy     = (r_state == S_RUN);
  assign o_done     = (r_state == S_DONE);
  assign o_ovf      = r_ovf;
  assign o_zero     = (r_data == '0);

endmodule

// File: tb/tb_mode_acc_reg.sv
// Directed table-driven bench for mode_acc_reg (WIDTH=4, SHIFT=1).
module tb_mode_acc_reg;

  localparam logic [2:0] LOAD = 3'b000, LSHL = 3'b001, INC = 3'b010, DEC = 3'b011;
  localparam logic [2:0] ADD = 3'b100, SUB = 3'b101, COUNT = 3'b110, CLR = 3'b111;
`ifdef SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [2:0] op;
  logic [3:0] din;
  logic [3:0] dout;
  logic       busy, done, ovf, zero;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       en;
    logic [2:0] op;
    logic [3:0] din;
    logic [3:0] d;
    logic       ovf;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  mode_acc_reg #(.WIDTH(4), .SHIFT(1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_op(op), .i_data_in(din),
    .o_data_out(dout), .o_busy(busy), .o_done(done), .o_ovf(ovf), .o_zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] d, input logic o,
                         input logic b, input logic dn);
    chk({tag, " data"}, dout, d);
    chk({tag, " ovf"},  {3'b0, ovf},  {3'b0, o});
    chk({tag, " zero"}, {3'b0, zero}, {3'b0, (d == 4'h0)});
    chk({tag, " busy"}, {3'b0, busy}, {3'b0, b});
    chk({tag, " done"}, {3'b0, done}, {3'b0, dn});
  endtask

  function automatic void mk(input logic e, input logic [2:0] o, input logic [3:0] di,
                             input logic [3:0] d, input logic v, input logic b, input logic dn);
    vec_t t;
    t.en = e; t.op = o; t.din = di; t.d = d; t.ovf = v; t.busy = b; t.done = dn;
    vecs.push_back(t);
  endfunction

  task automatic step(input logic e, input logic [2:0] o, input logic [3:0] di);
    en = e; op = o; din = di;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Single ops, overflow and saturation behaviour
    mk(1, LOAD, 4'h9, 4'h9, 0, 0, 0);
    mk(1, LSHL, 4'h5, 4'hA, 0, 0, 0);
    mk(1, LOAD, 4'hF, 4'hF, 0, 0, 0);
    mk(1, INC,  4'h0, SAT ? 4'hF : 4'h0, 1, 0, 0);
    mk(0, INC,  4'h0, SAT ? 4'hF : 4'h0, 1, 0, 0);
    mk(1, CLR,  4'h0, 4'h0, 0, 0, 0);
    mk(1, LOAD, 4'h3, 4'h3, 0, 0, 0);
    mk(1, SUB,  4'h5, SAT ? 4'h0 : 4'hE, 1, 0, 0);
    mk(1, LSHL, 4'h9, SAT ? 4'hF : 4'h2, 1, 0, 0);
    mk(1, CLR,  4'h0, 4'h0, 0, 0, 0);
    mk(1, DEC,  4'h0, SAT ? 4'h0 : 4'hF, 1, 0, 0);
    mk(1, CLR,  4'h0, 4'h0, 0, 0, 0);
    mk(1, LOAD, 4'h7, 4'h7, 0, 0, 0);
    mk(1, ADD,  4'h5, 4'hC, 0, 0, 0);
    mk(1, ADD,  4'h6, SAT ? 4'hF : 4'h2, 1, 0, 0);
    mk(1, CLR,  4'h0, 4'h0, 0, 0, 0);
    // COUNT 3 -> 6; ops during RUN ignored; DONE accepts a LOAD
    mk(1, LOAD,  4'h3, 4'h3, 0, 0, 0);
    mk(1, COUNT, 4'h6, 4'h3, 0, 1, 0);
    mk(1, LOAD,  4'h0, 4'h4, 0, 1, 0);
    mk(0, LOAD,  4'h0, 4'h5, 0, 1, 0);
    mk(1, INC,   4'h0, 4'h6, 0, 1, 0);
    mk(0, LOAD,  4'h0, 4'h6, 0, 0, 1);
    mk(1, LOAD,  4'h8, 4'h8, 0, 0, 0);
    mk(0, LOAD,  4'h0, 4'h8, 0, 0, 0);
    // COUNT wrapping E -> 1
    mk(1, LOAD,  4'hE, 4'hE, 0, 0, 0);
    mk(1, COUNT, 4'h1, 4'hE, 0, 1, 0);
    mk(0, LOAD,  4'h0, 4'hF, 0, 1, 0);
    mk(0, LOAD,  4'h0, 4'h0, 0, 1, 0);
    mk(0, LOAD,  4'h0, 4'h1, 0, 1, 0);
    mk(0, LOAD,  4'h0, 4'h1, 0, 0, 1);
    mk(0, LOAD,  4'h0, 4'h1, 0, 0, 0);
    // Abort mid-RUN with ovf set beforehand
    mk(1, LOAD,  4'hF, 4'hF, 0, 0, 0);
    mk(1, INC,   4'h0, SAT ? 4'hF : 4'h0, 1, 0, 0);
    mk(1, LOAD,  4'hE, 4'hE, 1, 0, 0);
    mk(1, COUNT, 4'h1, 4'hE, 1, 1, 0);
    mk(0, LOAD,  4'h0, 4'hF, 1, 1, 0);
    mk(1, CLR,   4'h0, 4'h0, 0, 0, 0);
    mk(0, LOAD,  4'h0, 4'h0, 0, 0, 0);
    mk(0, LOAD,  4'h0, 4'h0, 0, 0, 0);

    rst_n = 1'b0; en = 1'b0; op = LOAD; din = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 4'h0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("post-reset", 4'h0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].en, vecs[i].op, vecs[i].din);
      chk_all($sformatf("vec%0d", i), vecs[i].d, vecs[i].ovf, vecs[i].busy, vecs[i].done);
      $display("vec%0d en=%b op=%b din=%h -> data=%h ovf=%b busy=%b done=%b",
               i, vecs[i].en, vecs[i].op, vecs[i].din, dout, ovf, busy, done);
    end

    // Asynchronous reset mid-COUNT, then normal operation after release
    step(1, LOAD, 4'h2);
    step(1, COUNT, 4'h9);
    step(0, LOAD, 4'h0);
    step(0, LOAD, 4'h0);
    chk_all("pre-async", 4'h4, 0, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async-rst", 4'h0, 0, 0, 0);
    $display("async reset mid-COUNT -> data=%h busy=%b done=%b", dout, busy, done);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, LOAD, 4'h5);
    chk_all("after-rst load", 4'h5, 0, 0, 0);
    step(1, INC, 4'h0);
    chk_all("after-rst inc", 4'h6, 0, 0, 0);
    $display("post-release LOAD 5, INC -> data=%h", dout);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
